sort_batch_ctrl: RTL and testbench

Streaming front-end controller for the 8-entry, 8-bit selection-sort circuit. It accepts a batch of 8 bytes on a valid/ready input stream and writes them into the sorter. It then starts the sort, waits for completion under a watchdog, and reads the 8 sorted bytes back out in ascending order on a valid/ready output stream. It sits between the system data streams and the sorter's host port (`start`, `wr`, `addr`, `datain`, `dataout`, `ready`, `nrst`).

---
 rtl/sort_batch_ctrl.sv | 100 ++++++++++
 tb/tb_sort_batch_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_batch_ctrl.sv
// Streaming front-end for the 8-entry selection sorter: loads a batch of 8 bytes,
// starts the sort under a watchdog, then streams the sorted bytes back out.
module sort_batch_ctrl #(
  parameter int TIMEOUT = 127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       err,
  output logic [7:0] batches,
  output logic       srt_nrst,
  output logic       srt_start,
  output logic       srt_wr,
  output logic [2:0] srt_addr,
  output logic [7:0] srt_datain,
  input  logic [7:0] srt_dataout,
  input  logic       srt_ready
);

  typedef enum logic [2:0] {LOAD, START, SORT, RD_ADDR, RD_CAP, RD_OUT} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] timer;

  assign in_ready   = (state == LOAD) && srt_ready && !rst;
  assign srt_wr     = in_ready && in_valid;
  assign srt_datain = in_data;
  assign srt_addr   = cnt;
  assign srt_nrst   = ~rst;
  assign srt_start  = (state == START) && !rst;
  assign out_valid  = (state == RD_OUT) && !rst;
  assign out_last   = out_valid && (cnt == 3'd7);
  assign busy       = (state != LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      cnt      <= 3'd0;
      timer    <= 8'd0;
      out_data <= 8'd0;
      err      <= 1'b0;
      batches  <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          // cnt wraps 7 -> 0 on the last write, leaving it ready for readout
          if (srt_wr) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= START;
          end
        end
        START: begin
          timer <= 8'd0;
          state <= SORT;
        end
        SORT: begin
          timer <= timer + 8'd1;
          // timer==0 marks the first SORT cycle, where srt_ready is still stale
          if (timer != 8'd0 && srt_ready) begin
            cnt   <= 3'd0;
            state <= RD_ADDR;
          end else if (timer == TMO) begin
            err   <= 1'b1;
            cnt   <= 3'd0;
            state <= LOAD;
          end
        end
        RD_ADDR: state <= RD_CAP;
        RD_CAP: begin
          out_data <= srt_dataout;
          state    <= RD_OUT;
        end
        RD_OUT: begin
          if (out_ready) begin
            if (cnt == 3'd7) begin
              batches <= batches + 8'd1;
              cnt     <= 3'd0;
              state   <= LOAD;
            end else begin
              cnt   <= cnt + 3'd1;
              state <= RD_ADDR;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_batch_ctrl.sv
// Bench for sort_batch_ctrl: stub sorter plus a queue-based reference (sorted input batch).
module tb_sort_batch_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       err;
  logic [7:0] batches;
  logic       srt_nrst, srt_start, srt_wr;
  logic [2:0] srt_addr;
  logic [7:0] srt_datain;
  logic [7:0] srt_dataout;
  logic       srt_ready;

  sort_batch_ctrl #(.TIMEOUT(127)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err), .batches(batches),
    .srt_nrst(srt_nrst), .srt_start(srt_start), .srt_wr(srt_wr), .srt_addr(srt_addr),
    .srt_datain(srt_datain), .srt_dataout(srt_dataout), .srt_ready(srt_ready)
  );

  always #5 clk = ~clk;

  // Stub sorter: registered read port, drops ready on start, sorts after a delay.
  logic [63:0] mem = 64'd0;
  logic        s_ready = 1'b0;
  logic [7:0]  s_delay = 8'd0;
  logic [7:0]  s_dout = 8'd0;
  logic [7:0]  sort_delay = 8'd10;
  logic        stuck = 1'b0;

  function automatic logic [63:0] sorted8(input logic [63:0] m);
    logic [63:0] r;
    logic [7:0]  t;
    r = m;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (r[j*8 +: 8] > r[(j+1)*8 +: 8]) begin
          t = r[j*8 +: 8];
          r[j*8 +: 8] = r[(j+1)*8 +: 8];
          r[(j+1)*8 +: 8] = t;
        end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!srt_nrst) begin
      s_ready <= 1'b1;
      s_delay <= 8'd0;
    end else begin
      if (srt_wr) mem[32'(srt_addr)*8 +: 8] <= srt_datain;
      if (srt_start) begin
        s_ready <= 1'b0;
        s_delay <= sort_delay;
      end else if (!s_ready && !stuck) begin
        if (s_delay == 8'd0) begin
          mem     <= sorted8(mem);
          s_ready <= 1'b1;
        end else s_delay <= s_delay - 8'd1;
      end
    end
    s_dout <= mem[32'(srt_addr)*8 +: 8];
  end
  assign srt_dataout = s_dout;
  assign srt_ready   = s_ready;

  int         checks = 0;
  int         errors = 0;
  int         nb = 0;
  logic [7:0] bat [8];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive bat[] with ~gap% bubbles; ends in the START cycle.
  task automatic load_batch(input int gap);
    int n = 0;
    int cyc = 0;
    int wr = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(bat[i]);
    exp_q.sort();
    sort_delay = 8'($urandom_range(40, 3));
    while (n < 8 && cyc < 400) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) >= gap);
      in_data  = bat[n];
      #1;
      chk("in_ready_load", {31'd0, in_ready}, 32'd1);
      chk("srt_wr_hs", {31'd0, srt_wr}, {31'd0, in_valid});
      if (srt_wr) wr++;
      if (in_valid && in_ready) n++;
      cyc++;
    end
    chk("writes", wr, 8);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("start_pulse", {31'd0, srt_start}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  // Collect 8 outputs; hold out_ready low hold_cyc cycles on output hold_idx.
  task automatic collect(input int hold_idx, input int hold_cyc, input bit rnd);
    int got = 0;
    int cyc = 0;
    int stall = 0;
    logic [7:0] held = 8'd0;
    while (got < 8 && cyc < 3000) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        if (got == hold_idx && stall < hold_cyc) begin
          if (stall == 0) held = out_data;
          else begin
            chk("hold_data", {24'd0, out_data}, {24'd0, held});
            chk("hold_last", {31'd0, out_last}, 32'd0);
          end
          stall++;
          out_ready = 1'b0;
        end else if (rnd && $urandom_range(1) == 0) begin
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          chk("out_data", {24'd0, out_data}, {24'd0, exp_q[got]});
          chk("out_last", {31'd0, out_last}, {31'd0, got == 7});
          got++;
        end
      end else out_ready = 1'b1;
      cyc++;
    end
    chk("outputs_seen", got, 8);
    nb++;
    @(negedge clk);
    #1;
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("batches", {24'd0, batches}, 32'(nb & 255));
  endtask

  task automatic set_bat(input logic [63:0] v);
    for (int i = 0; i < 8; i++) bat[i] = v[(7-i)*8 +: 8];
  endtask

  initial begin
    int c;
    bit seen;
    // reset
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_srt_wr", {31'd0, srt_wr}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_srt_nrst", {31'd0, srt_nrst}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel_busy", {31'd0, busy}, 32'd0);
    chk("rel_err", {31'd0, err}, 32'd0);
    chk("rel_batches", {24'd0, batches}, 32'd0);
    chk("rel_out_data", {24'd0, out_data}, 32'd0);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    set_bat(64'h05_03_07_01_00_06_02_04);
    load_batch(0);  collect(-1, 0, 0);
    set_bat(64'h09_09_01_01_FF_00_09_01);
    load_batch(0);  collect(-1, 0, 0);
    set_bat(64'h07_06_05_04_03_02_01_00);
    load_batch(0);  collect(-1, 0, 0);

    // backpressure on the 3rd output byte
    for (int i = 0; i < 8; i++) bat[i] = 8'($urandom_range(255));
    load_batch(0);  collect(2, 10, 0);

    // random input gaps and random output stalls
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) bat[i] = 8'($urandom_range(255));
      load_batch(50);  collect(-1, 0, 1);
    end

    // stuck sorter -> watchdog abort
    stuck = 1'b1;
    for (int i = 0; i < 8; i++) bat[i] = 8'($urandom_range(255));
    load_batch(0);
    sort_delay = 8'd3;
    c = 0;
    seen = 1'b0;
    while (!err && c < 400) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
      c++;
    end
    chk("wd_err", {31'd0, err}, 32'd1);
    chk("wd_no_out", {31'd0, seen}, 32'd0);
    chk("wd_window", {31'd0, (c >= 125 && c <= 132)}, 32'd1);
    chk("wd_busy", {31'd0, busy}, 32'd0);
    chk("wd_batches", {24'd0, batches}, 32'(nb & 255));
    stuck = 1'b0;
    repeat (60) @(negedge clk);

    // later batch still works; err stays sticky
    for (int i = 0; i < 8; i++) bat[i] = 8'($urandom_range(255));
    load_batch(0);  collect(-1, 0, 0);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // reset during SORT
    for (int i = 0; i < 8; i++) bat[i] = 8'($urandom_range(255));
    load_batch(0);
    sort_delay = 8'd30;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("mid_rst_busy_pre", {31'd0, busy}, 32'd1);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_srt_start", {31'd0, srt_start}, 32'd0);
    chk("mid_rst_srt_wr", {31'd0, srt_wr}, 32'd0);
    chk("mid_rst_srt_nrst", {31'd0, srt_nrst}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    nb = 0;
    chk("after_rst_busy", {31'd0, busy}, 32'd0);
    chk("after_rst_err", {31'd0, err}, 32'd0);
    chk("after_rst_batches", {24'd0, batches}, 32'd0);
    chk("after_rst_out_data", {24'd0, out_data}, 32'd0);
    set_bat(64'h03_01_02_00_07_05_06_04);
    load_batch(0);  collect(-1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
